// File: rtl/contador_bcd_multidigito.sv
// Prescaled N-digit BCD up/down counter with load, clear, wrap/saturate mode
// and per-digit active-low 7-segment decode.
module contador_bcd_multidigito #(
   parameter int N_DIGITS = 4,
   parameter int PRESCALE = 25000000,
   parameter int WRAP     = 1
) (
   input  logic                    iCLOCK,
   input  logic                    iRESET_n,
   input  logic                    iENABLE,
   input  logic                    iUP_DOWN,
   input  logic                    iCLEAR,
   input  logic                    iLOAD,
   input  logic [4*N_DIGITS-1:0]   iLOAD_VALUE,
   output logic [4*N_DIGITS-1:0]   oCOUNT,
   output logic [7*N_DIGITS-1:0]   o7SEG,
   output logic                    oTICK,
   output logic                    oTC,
   output logic                    oSAT
);

   localparam int            PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0]           presc_reg;
   logic                    tick_reg;
   logic                    tc_reg;
   logic [4*N_DIGITS-1:0]   count_reg;

   logic [N_DIGITS:0]       nines_below;
   logic [N_DIGITS:0]       zeros_below;
   logic [4*N_DIGITS-1:0]   inc_value;
   logic [4*N_DIGITS-1:0]   dec_value;
   logic [4*N_DIGITS-1:0]   load_clamped;
   logic                    all_nines;
   logic                    all_zeros;
   logic                    presc_wrap;

   assign nines_below[0] = 1'b1;
   assign zeros_below[0] = 1'b1;

   // Ripple chain: a digit moves only when every lower digit is at its bound.
   generate
      for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
         logic [3:0] digit;
         logic [3:0] load_digit;
         logic [6:0] seg_digit;

         assign digit      = count_reg[4*gi +: 4];
         assign load_digit = iLOAD_VALUE[4*gi +: 4];

         assign nines_below[gi+1] = nines_below[gi] & (digit == 4'd9);
         assign zeros_below[gi+1] = zeros_below[gi] & (digit == 4'd0);

         assign inc_value[4*gi +: 4] = !nines_below[gi] ? digit :
                                       (digit == 4'd9) ? 4'd0 : digit + 4'd1;
         assign dec_value[4*gi +: 4] = !zeros_below[gi] ? digit :
                                       (digit == 4'd0) ? 4'd9 : digit - 4'd1;
         assign load_clamped[4*gi +: 4] = (load_digit > 4'd9) ? 4'd9 : load_digit;

         always_comb begin
            case (digit)
               4'h0:    seg_digit = 7'b1000000;
               4'h1:    seg_digit = 7'b1111001;
               4'h2:    seg_digit = 7'b0100100;
               4'h3:    seg_digit = 7'b0110000;
               4'h4:    seg_digit = 7'b0011001;
               4'h5:    seg_digit = 7'b0010010;
               4'h6:    seg_digit = 7'b0000010;
               4'h7:    seg_digit = 7'b1111000;
               4'h8:    seg_digit = 7'b0000000;
               4'h9:    seg_digit = 7'b0010000;
               4'hA:    seg_digit = 7'b0001000;
               4'hB:    seg_digit = 7'b0000011;
               4'hC:    seg_digit = 7'b1000110;
               4'hD:    seg_digit = 7'b0100001;
               4'hE:    seg_digit = 7'b0000110;
               default: seg_digit = 7'b0001110;
            endcase
         end

         assign o7SEG[7*gi +: 7] = seg_digit;
      end
   endgenerate

   assign all_nines  = nines_below[N_DIGITS];
   assign all_zeros  = zeros_below[N_DIGITS];
   assign presc_wrap = iENABLE && (presc_reg == P_LAST);

   always_ff @(posedge iCLOCK or negedge iRESET_n) begin
      if (!iRESET_n) begin
         presc_reg <= '0;
         tick_reg  <= 1'b0;
         tc_reg    <= 1'b0;
         count_reg <= '0;
      end else if (iCLEAR) begin
         presc_reg <= '0;
         tick_reg  <= 1'b0;
         tc_reg    <= 1'b0;
         count_reg <= '0;
      end else begin
         tick_reg <= presc_wrap;
         tc_reg   <= 1'b0;
         if (iENABLE)
            presc_reg <= presc_wrap ? '0 : presc_reg + 1'b1;
         // A load wins over a coincident step; the prescaler keeps its phase.
         if (iLOAD) begin
            count_reg <= load_clamped;
         end else if (presc_wrap) begin
            if (iUP_DOWN) begin
               if (!all_nines) begin
                  count_reg <= inc_value;
               end else if (WRAP != 0) begin
                  count_reg <= '0;
                  tc_reg    <= 1'b1;
               end
            end else begin
               if (!all_zeros) begin
                  count_reg <= dec_value;
               end else if (WRAP != 0) begin
                  count_reg <= {N_DIGITS{4'd9}};
                  tc_reg    <= 1'b1;
               end
            end
         end
      end
   end

   assign oCOUNT = count_reg;
   assign oTICK  = tick_reg;
   assign oTC    = tc_reg;
   assign oSAT   = (WRAP == 0) && (iUP_DOWN ? all_nines : all_zeros);

endmodule

// File: tb/tb_contador_bcd_multidigito.sv
// Bench for contador_bcd_multidigito: three configurations share one stimulus
// stream and are checked every cycle against an integer-valued counter model.
module tb_contador_bcd_multidigito;

   localparam int NI = 3;
   localparam int ND[NI] = '{2, 2, 3};
   localparam int PS[NI] = '{4, 4, 1};
   localparam int WR[NI] = '{1, 0, 1};

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en = 1'b0;
   logic        ud = 1'b1;
   logic        clr = 1'b0;
   logic        ld = 1'b0;
   logic [11:0] lv = '0;

   logic [7:0]  count_a, count_b;
   logic [11:0] count_c;
   logic [13:0] seg_a, seg_b;
   logic [20:0] seg_c;
   logic        tick_a, tick_b, tick_c;
   logic        tc_a, tc_b, tc_c;
   logic        sat_a, sat_b, sat_c;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   contador_bcd_multidigito #(.N_DIGITS(2), .PRESCALE(4), .WRAP(1)) dut_a (
      .iCLOCK(clk), .iRESET_n(rst_n), .iENABLE(en), .iUP_DOWN(ud), .iCLEAR(clr),
      .iLOAD(ld), .iLOAD_VALUE(lv[7:0]), .oCOUNT(count_a), .o7SEG(seg_a),
      .oTICK(tick_a), .oTC(tc_a), .oSAT(sat_a));

   contador_bcd_multidigito #(.N_DIGITS(2), .PRESCALE(4), .WRAP(0)) dut_b (
      .iCLOCK(clk), .iRESET_n(rst_n), .iENABLE(en), .iUP_DOWN(ud), .iCLEAR(clr),
      .iLOAD(ld), .iLOAD_VALUE(lv[7:0]), .oCOUNT(count_b), .o7SEG(seg_b),
      .oTICK(tick_b), .oTC(tc_b), .oSAT(sat_b));

   contador_bcd_multidigito #(.N_DIGITS(3), .PRESCALE(1), .WRAP(1)) dut_c (
      .iCLOCK(clk), .iRESET_n(rst_n), .iENABLE(en), .iUP_DOWN(ud), .iCLEAR(clr),
      .iLOAD(ld), .iLOAD_VALUE(lv), .oCOUNT(count_c), .o7SEG(seg_c),
      .oTICK(tick_c), .oTC(tc_c), .oSAT(sat_c));

   logic [31:0] g_cnt[NI];
   logic [31:0] g_seg[NI];
   logic        g_tick[NI], g_tc[NI], g_sat[NI];
   assign g_cnt[0] = {24'b0, count_a};
   assign g_cnt[1] = {24'b0, count_b};
   assign g_cnt[2] = {20'b0, count_c};
   assign g_seg[0] = {18'b0, seg_a};
   assign g_seg[1] = {18'b0, seg_b};
   assign g_seg[2] = {11'b0, seg_c};
   assign g_tick = '{tick_a, tick_b, tick_c};
   assign g_tc   = '{tc_a, tc_b, tc_c};
   assign g_sat  = '{sat_a, sat_b, sat_c};

   // Hex-display glyphs for decimal digits 0..9, active low, bit0 = segment a.
   logic [6:0] seg_tab[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

   function automatic int max_val(int nd);
      int m = 1;
      for (int k = 0; k < nd; k++) m = m * 10;
      return m - 1;
   endfunction

   function automatic logic [31:0] to_bcd(int v, int nd);
      logic [31:0] r = '0;
      int x = v;
      for (int k = 0; k < nd; k++) begin
         r = r | (32'(x % 10) << (4 * k));
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [31:0] to_seg(int v, int nd);
      logic [31:0] r = '0;
      int x = v;
      for (int k = 0; k < nd; k++) begin
         r = r | (32'(seg_tab[x % 10]) << (7 * k));
         x = x / 10;
      end
      return r;
   endfunction

   function automatic int clamp_load(logic [11:0] v, int nd);
      int acc = 0;
      int pw = 1;
      for (int k = 0; k < nd; k++) begin
         int d = int'((v >> (4 * k)) & 12'hF);
         if (d > 9) d = 9;
         acc = acc + d * pw;
         pw = pw * 10;
      end
      return acc;
   endfunction

   task automatic chk(string name, int inst, logic [31:0] got, logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s inst%0d got %h expected %h at %0t", name, inst, got, exp, $time);
      end
   endtask

   // Reference model: the count is held as a plain decimal integer.
   int m_cnt[NI] = '{0, 0, 0};
   int m_p[NI]   = '{0, 0, 0};
   bit m_tick[NI] = '{0, 0, 0};
   bit m_tc[NI]   = '{0, 0, 0};

   always @(posedge clk or negedge rst_n) begin
      int c, mx;
      bit step, wrapped;
      if (!rst_n) begin
         for (int i = 0; i < NI; i++) begin
            m_cnt[i] <= 0; m_p[i] <= 0; m_tick[i] <= 0; m_tc[i] <= 0;
         end
      end else begin
         for (int i = 0; i < NI; i++) begin
            if (clr) begin
               m_cnt[i] <= 0; m_p[i] <= 0; m_tick[i] <= 0; m_tc[i] <= 0;
            end else begin
               step = en && (m_p[i] == PS[i] - 1);
               if (en) m_p[i] <= step ? 0 : m_p[i] + 1;
               m_tick[i] <= step;
               c = m_cnt[i];
               mx = max_val(ND[i]);
               wrapped = 0;
               if (ld) c = clamp_load(lv, ND[i]);
               else if (step && ud) begin
                  if (c < mx) c = c + 1;
                  else if (WR[i] != 0) begin c = 0; wrapped = 1; end
               end else if (step) begin
                  if (c > 0) c = c - 1;
                  else if (WR[i] != 0) begin c = mx; wrapped = 1; end
               end
               m_cnt[i] <= c;
               m_tc[i]  <= wrapped;
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < NI; i++) begin
         bit exp_sat;
         exp_sat = (WR[i] == 0) && ((ud && m_cnt[i] == max_val(ND[i])) || (!ud && m_cnt[i] == 0));
         chk("count", i, g_cnt[i], to_bcd(m_cnt[i], ND[i]));
         chk("seg",   i, g_seg[i], to_seg(m_cnt[i], ND[i]));
         chk("tick",  i, 32'(g_tick[i]), 32'(m_tick[i]));
         chk("tc",    i, 32'(g_tc[i]),   32'(m_tc[i]));
         chk("sat",   i, 32'(g_sat[i]),  32'(exp_sat));
      end
   end

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_tick();
      bit seen = 0;
      for (int k = 0; k < 12 && !seen; k++) begin
         cyc(1);
         seen = tick_a;
      end
      chk("tick_timeout", 0, 32'(seen), 32'd1);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      cyc(2);
      chk("lit_reset_count", 0, {24'b0, count_a}, 32'h00);
      chk("lit_reset_seg",   0, {18'b0, seg_a}, {18'b0, 14'b1000000_1000000});
      chk("lit_reset_sat_b", 1, 32'(sat_b), 32'd0);
      ud = 1'b0; #1;
      chk("lit_reset_sat_b_down", 1, 32'(sat_b), 32'd1);

      // Free count up from reset: ticks on cycles 4, 8, 12, 16.
      ud = 1'b1; rst_n = 1'b1; en = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         cyc(1);
         chk("lit_tick_phase", 0, 32'(tick_a), 32'((i % 4) == 0));
      end
      chk("lit_count_04", 0, {24'b0, count_a}, 32'h04);
      chk("lit_seg_4",    0, {25'b0, seg_a[6:0]}, 32'b0011001);

      // Upper bound: wrap on A, saturate on B.
      ld = 1'b1; lv = 12'h098; cyc(1); ld = 1'b0;
      wait_tick();
      chk("lit_99", 0, {24'b0, count_a}, 32'h99);
      wait_tick();
      chk("lit_wrap_00", 0, {24'b0, count_a}, 32'h00);
      chk("lit_wrap_tc", 0, 32'(tc_a), 32'd1);
      chk("lit_sat_hold", 1, {24'b0, count_b}, 32'h99);
      chk("lit_sat_flag", 1, 32'(sat_b), 32'd1);
      cyc(1);
      chk("lit_tc_one_cycle", 0, 32'(tc_a), 32'd0);
      ud = 1'b0; #1;
      chk("lit_sat_dir_flip", 1, 32'(sat_b), 32'd0);
      wait_tick();
      chk("lit_sat_down_98", 1, {24'b0, count_b}, 32'h98);

      // Downward borrow and lower-bound wrap.
      ld = 1'b1; lv = 12'h010; cyc(1); ld = 1'b0;
      wait_tick();
      chk("lit_09", 0, {24'b0, count_a}, 32'h09);
      wait_tick();
      chk("lit_08", 0, {24'b0, count_a}, 32'h08);
      ld = 1'b1; lv = 12'h000; cyc(1); ld = 1'b0;
      wait_tick();
      chk("lit_down_wrap_99", 0, {24'b0, count_a}, 32'h99);
      chk("lit_down_wrap_tc", 0, 32'(tc_a), 32'd1);

      // Load clamping, clear priority, load on a tick edge.
      ld = 1'b1; lv = 12'h0A5; cyc(1);
      chk("lit_clamp_95", 0, {24'b0, count_a}, 32'h95);
      clr = 1'b1; lv = 12'h055; cyc(1);
      chk("lit_clear_wins", 0, {24'b0, count_a}, 32'h00);
      clr = 1'b0; ld = 1'b0;
      wait_tick();
      cyc(3);
      ld = 1'b1; lv = 12'h037; cyc(1); ld = 1'b0;
      chk("lit_load_on_tick_tick", 0, 32'(tick_a), 32'd1);
      chk("lit_load_on_tick_val", 0, {24'b0, count_a}, 32'h37);
      cyc(1);
      chk("lit_step_lost", 0, {24'b0, count_a}, 32'h37);

      // Freeze, then reset mid-period.
      en = 1'b0; cyc(5);
      en = 1'b1; cyc(2);
      rst_n = 1'b0; #1;
      chk("lit_async_rst_a", 0, {24'b0, count_a}, 32'h00);
      chk("lit_async_rst_c", 2, {20'b0, count_c}, 32'h000);
      cyc(1);
      rst_n = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         cyc(1);
         chk("lit_first_tick_p4", 0, 32'(tick_a), 32'(i == 4));
         chk("lit_first_tick_p1", 2, 32'(tick_c), 32'd1);
      end

      // Randomised run against the model.
      for (int i = 0; i < 3000; i++) begin
         en    = ($urandom_range(0, 9) < 8);
         ud    = 1'($urandom_range(0, 1));
         clr   = ($urandom_range(0, 49) == 0);
         ld    = ($urandom_range(0, 19) == 0);
         lv    = 12'($urandom);
         rst_n = ($urandom_range(0, 199) != 0);
         cyc(1);
      end
      rst_n = 1'b1; clr = 1'b0; ld = 1'b0;
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
